// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the game controller slice: FSM state
//               encodings, default game parameters and a saturating score
//               increment helper. Imported by game_ctl and its neighbours
//               (ball controller, display overlay).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    // FSM state encodings (also driven out on state_out)
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_SERVE_WAIT = 3'd1;
    localparam logic [2:0] c_ST_PLAY       = 3'd2;
    localparam logic [2:0] c_ST_POINT      = 3'd3;
    localparam logic [2:0] c_ST_GAME_OVER  = 3'd4;

    // Game defaults
    localparam int          c_LIVES_DEFAULT       = 3;
    localparam logic [23:0] c_SERVE_DELAY_DEFAULT = 24'd6_500_000;

    localparam logic [9:0]  c_SCORE_MAX = 10'd1023;

    // Score increment that sticks at the maximum instead of wrapping
    function automatic logic [9:0] score_sat_inc(input logic [9:0] i_score);
        return (i_score == c_SCORE_MAX) ? i_score : i_score + 10'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_ctl_edge_det.sv
// ============================================================================
// Module      : edge_det
// Description : Rising-edge detector. The input level is delayed by one
//               register; o_rise = i_level & ~delayed level.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset (clears delay reg)
//               i_level - level input, already in the clk domain
//               o_rise  - high for one cycle after a 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/game_ctl.sv
// ============================================================================
// Module      : game_ctl
// Description : Game-flow controller for a single-player paddle game. Starts
//               a game on a mouse click, waits out a serve delay, counts
//               paddle returns, tracks lives and reports game over. The ball
//               controller is started/stopped solely by ball_toggle pulses.
// Config      : GAME_CTL_AUTOSERVE_EN - when defined, the serve happens as
//               soon as the serve delay expires; otherwise it waits for the
//               first click after the delay expires.
// Parameters  : PADDLE_X    - ball x at which a paddle return is counted
//               MISS_X      - ball x below which the ball is lost
//               LIVES       - lives per game (1..3)
//               SERVE_DELAY - serve wait length in pclk cycles
// Ports       : pclk          in   pixel clock
//               rst           in   asynchronous active-high reset
//               mouse_left    in   left button level (pclk domain)
//               difficulty_in in   0 easy, 1 hard
//               ball_xpos     in   ball x position [11:0]
//               ball_toggle   out  one-cycle start/stop pulse to ball ctl
//               difficulty    out  difficulty latched at game start
//               score         out  returns this game [9:0], saturating
//               lives         out  lives remaining [1:0]
//               state_out     out  FSM state encoding [2:0]
//               game_over     out  high while in GAME_OVER
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctl
    import game_pkg::*;
#(
    parameter int          PADDLE_X    = 60,
    parameter int          MISS_X      = 40,
    parameter int          LIVES       = c_LIVES_DEFAULT,
    parameter logic [23:0] SERVE_DELAY = c_SERVE_DELAY_DEFAULT
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic        difficulty_in,
    input  logic [11:0] ball_xpos,
    output logic        ball_toggle,
    output logic        difficulty,
    output logic [9:0]  score,
    output logic [1:0]  lives,
    output logic [2:0]  state_out,
    output logic        game_over
);

    localparam logic [11:0] c_PADDLE_X    = 12'(PADDLE_X);
    localparam logic [11:0] c_PADDLE_X_P1 = 12'(PADDLE_X + 1);
    localparam logic [11:0] c_MISS_X      = 12'(MISS_X);
    localparam logic [1:0]  c_LIVES       = 2'(LIVES);
    localparam logic [23:0] c_SERVE_LAST  = SERVE_DELAY - 24'd1;

    // Registered state
    logic [2:0]  r_state;
    logic [9:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_difficulty;
    logic        r_ball_toggle;
    logic        r_game_over;
    logic [23:0] r_serve_cnt;
    logic [11:0] r_xpos_d;

    // Next-state values
    logic [2:0]  w_state_nx;
    logic [9:0]  w_score_nx;
    logic [1:0]  w_lives_nx;
    logic        w_difficulty_nx;
    logic        w_ball_toggle_nx;
    logic        w_game_over_nx;
    logic [23:0] w_serve_cnt_nx;

    logic w_rise;
    logic w_serve_ready;
    logic w_serve;
    logic w_miss;
    logic w_return;

    edge_det u_edge_det (
        .clk     (pclk),
        .rst     (rst),
        .i_level (mouse_left),
        .o_rise  (w_rise)
    );

    assign w_serve_ready = (r_serve_cnt == c_SERVE_LAST);

`ifdef GAME_CTL_AUTOSERVE_EN
    assign w_serve = w_serve_ready;
`else
    assign w_serve = w_serve_ready & w_rise;
`endif

    // A miss is not taken in the cycle right after a toggle pulse, so two
    // pulses can never be back to back (e.g. a ball served from x < MISS_X).
    assign w_miss   = (ball_xpos < c_MISS_X) & ~r_ball_toggle;
    assign w_return = (r_xpos_d == c_PADDLE_X) & (ball_xpos == c_PADDLE_X_P1);

    always_comb begin
        w_state_nx       = r_state;
        w_score_nx       = r_score;
        w_lives_nx       = r_lives;
        w_difficulty_nx  = r_difficulty;
        w_serve_cnt_nx   = r_serve_cnt;
        w_ball_toggle_nx = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx      = c_ST_SERVE_WAIT;
                    w_score_nx      = 10'd0;
                    w_lives_nx      = c_LIVES;
                    w_difficulty_nx = difficulty_in;
                    w_serve_cnt_nx  = 24'd0;
                end
            end
            c_ST_SERVE_WAIT: begin
                if (w_serve) begin
                    w_ball_toggle_nx = 1'b1;
                    w_state_nx       = c_ST_PLAY;
                end else if (!w_serve_ready) begin
                    w_serve_cnt_nx = r_serve_cnt + 24'd1;
                end
            end
            c_ST_PLAY: begin
                // Miss takes priority over a simultaneous return
                if (w_miss) begin
                    w_ball_toggle_nx = 1'b1;
                    w_lives_nx       = r_lives - 2'd1;
                    w_state_nx       = c_ST_POINT;
                end else if (w_return) begin
                    w_score_nx = score_sat_inc(r_score);
                end
            end
            c_ST_POINT: begin
                if (r_lives == 2'd0) begin
                    w_state_nx = c_ST_GAME_OVER;
                end else begin
                    w_state_nx     = c_ST_SERVE_WAIT;
                    w_serve_cnt_nx = 24'd0;
                end
            end
            c_ST_GAME_OVER: begin
                if (w_rise) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase

        w_game_over_nx = (w_state_nx == c_ST_GAME_OVER);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_score       <= 10'd0;
            r_lives       <= 2'd0;
            r_difficulty  <= 1'b0;
            r_ball_toggle <= 1'b0;
            r_game_over   <= 1'b0;
            r_serve_cnt   <= 24'd0;
            r_xpos_d      <= 12'd0;
        end else begin
            r_state       <= w_state_nx;
            r_score       <= w_score_nx;
            r_lives       <= w_lives_nx;
            r_difficulty  <= w_difficulty_nx;
            r_ball_toggle <= w_ball_toggle_nx;
            r_game_over   <= w_game_over_nx;
            r_serve_cnt   <= w_serve_cnt_nx;
            r_xpos_d      <= ball_xpos;
        end
    end

    assign ball_toggle = r_ball_toggle;
    assign difficulty  = r_difficulty;
    assign score       = r_score;
    assign lives       = r_lives;
    assign state_out   = r_state;
    assign game_over   = r_game_over;

endmodule

`default_nettype wire
